slot_idx_encoder: RTL and testbench

Registered index encoder for slot-based tracking tables (transaction guards, ID/linked-list pools). Each cycle it reduces two WIDTH-bit vectors to binary indices: a free-slot mask via a leading/trailing-zero counter (first free slot) and a match mask via a one-hot-to-binary encoder (matching slot). Results are registered, giving downstream allocation/dequeue logic a timing-clean, single-cycle-latency index source.

---
 rtl/slot_idx_encoder.sv | 167 ++++++++++++++++
 tb/tb_slot_idx_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slot_idx_encoder.sv
// Registered slot index encoder: first-free search (lzc) plus one-hot match encode.
// Define SLOT_IDX_ONEHOT_CHECK_EN to enable the multi-hot match error output.

module slot_idx_lzc #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int IdxW = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [IdxW-1:0]  cnt,
  output logic             empty
);

  logic found_s;

  // Zero count from the LSB (MODE 0) or from the MSB (MODE 1).
  always_comb begin
    cnt     = '0;
    found_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt     = (!found_s && in[(MODE == 1) ? (WIDTH - 1 - i) : i]) ? i[IdxW-1:0] : cnt;
      found_s = found_s | in[(MODE == 1) ? (WIDTH - 1 - i) : i];
    end
    empty = !found_s;
  end

endmodule

module slot_idx_onehot_to_bin #(
  parameter int WIDTH = 8,
  localparam int IdxW = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IdxW-1:0]  bin
);

  // OR of the indices of every set bit; no priority resolution.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin = onehot[i] ? (bin | i[IdxW-1:0]) : bin;
    end
  end

endmodule

module slot_idx_onehot_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             en,
  input logic [WIDTH-1:0] match
);

  // Report every enabled capture of a multi-hot match vector.
  always @(posedge clk) begin
    if (en && ((match & (match - WIDTH'(1))) != '0)) begin
      $error("slot_idx_encoder: multi-hot match vector %b", match);
    end else begin
    end
  end

endmodule

module slot_idx_encoder #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int IdxW = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] free_i,
  input  logic [WIDTH-1:0] match_i,
  output logic [IdxW-1:0]  free_idx_o,
  output logic             free_empty_o,
  output logic [IdxW-1:0]  match_idx_o,
  output logic             match_valid_o,
  output logic             match_err_o
);

  logic [IdxW-1:0] free_cnt_s;
  logic            free_empty_s;
  logic [IdxW-1:0] free_idx_s;
  logic [IdxW-1:0] match_idx_s;
  logic            match_valid_s;
  logic            match_err_s;

  logic [IdxW-1:0] free_idx_r;
  logic            free_empty_r;
  logic [IdxW-1:0] match_idx_r;
  logic            match_valid_r;
  logic            match_err_r;

  slot_idx_lzc #(.WIDTH(WIDTH), .MODE(MODE)) u_lzc (
    .in    (free_i),
    .cnt   (free_cnt_s),
    .empty (free_empty_s)
  );

  slot_idx_onehot_to_bin #(.WIDTH(WIDTH)) u_oh2bin (
    .onehot (match_i),
    .bin    (match_idx_s)
  );

`ifdef SLOT_IDX_ONEHOT_CHECK_EN
  function automatic logic multi_hot(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) != '0;
  endfunction

`ifndef SYNTHESIS
  slot_idx_onehot_chk #(.WIDTH(WIDTH)) u_chk (
    .clk   (clk_i),
    .en    (en_i),
    .match (match_i)
  );
`endif
`endif

  // Next-state values; a leading-zero count becomes an index from the MSB.
  always_comb begin
    free_idx_s    = '0;
    match_valid_s = |match_i;
`ifdef SLOT_IDX_ONEHOT_CHECK_EN
    match_err_s   = multi_hot(match_i);
`else
    match_err_s   = 1'b0;
`endif
    if (free_empty_s) begin
      free_idx_s = '0;
    end else if (MODE == 1) begin
      free_idx_s = IdxW'(WIDTH - 1) - free_cnt_s;
    end else begin
      free_idx_s = free_cnt_s;
    end
  end

  // Output registers, all captured together on enabled edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_idx_r    <= '0;
      free_empty_r  <= 1'b1;
      match_idx_r   <= '0;
      match_valid_r <= 1'b0;
      match_err_r   <= 1'b0;
    end else if (en_i) begin
      free_idx_r    <= free_idx_s;
      free_empty_r  <= free_empty_s;
      match_idx_r   <= match_idx_s;
      match_valid_r <= match_valid_s;
      match_err_r   <= match_err_s;
    end else begin
      free_idx_r    <= free_idx_r;
      free_empty_r  <= free_empty_r;
      match_idx_r   <= match_idx_r;
      match_valid_r <= match_valid_r;
      match_err_r   <= match_err_r;
    end
  end

  assign free_idx_o    = free_idx_r;
  assign free_empty_o  = free_empty_r;
  assign match_idx_o   = match_idx_r;
  assign match_valid_o = match_valid_r;
  assign match_err_o   = match_err_r;

endmodule

// File: tb/tb_slot_idx_encoder.sv
// Directed bench for slot_idx_encoder: MODE 0 and MODE 1 at WIDTH 8, plus WIDTH 1.

module tb_slot_idx_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] free;
  logic [7:0] match;
  logic [0:0] free1;
  logic [0:0] match1;

  logic [2:0] a_fidx, b_fidx, a_midx, b_midx;
  logic       a_fe, b_fe, a_mv, b_mv, a_me, b_me;
  logic [0:0] c_fidx, c_midx;
  logic       c_fe, c_mv, c_me;

  int errors = 0;
  int checks = 0;

`ifdef SLOT_IDX_ONEHOT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  slot_idx_encoder #(.WIDTH(8), .MODE(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .free_i(free), .match_i(match),
    .free_idx_o(a_fidx), .free_empty_o(a_fe), .match_idx_o(a_midx),
    .match_valid_o(a_mv), .match_err_o(a_me)
  );

  slot_idx_encoder #(.WIDTH(8), .MODE(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .free_i(free), .match_i(match),
    .free_idx_o(b_fidx), .free_empty_o(b_fe), .match_idx_o(b_midx),
    .match_valid_o(b_mv), .match_err_o(b_me)
  );

  slot_idx_encoder #(.WIDTH(1), .MODE(0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .free_i(free1), .match_i(match1),
    .free_idx_o(c_fidx), .free_empty_o(c_fe), .match_idx_o(c_midx),
    .match_valid_o(c_mv), .match_err_o(c_me)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [2:0] fidx, input logic fe,
                         input logic [2:0] midx, input logic mv, input logic me);
    check({tag, ".a_fidx"}, 32'(a_fidx), 32'(fidx));
    check({tag, ".a_fe"},   32'(a_fe),   32'(fe));
    check({tag, ".a_midx"}, 32'(a_midx), 32'(midx));
    check({tag, ".a_mv"},   32'(a_mv),   32'(mv));
    check({tag, ".a_me"},   32'(a_me),   32'(me));
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    free   = 8'hFF;
    match  = 8'h01;
    free1  = 1'b1;
    match1 = 1'b1;
    repeat (2) cycle();
    check_a("rst", 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    check("rst.b_fe", 32'(b_fe), 32'd1);
    check("rst.c_fe", 32'(c_fe), 32'd1);
    check("rst.c_mv", 32'(c_mv), 32'd0);

    // First capture after deassert with nothing free.
    rst_n = 1'b1;
    free  = 8'h00;
    match = 8'h00;
    free1 = 1'b0;
    match1 = 1'b0;
    cycle();
    check_a("empty", 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    check("empty.b_fe", 32'(b_fe), 32'd1);
    check("empty.b_fidx", 32'(b_fidx), 32'd0);
    check("empty.c_fe", 32'(c_fe), 32'd1);

    free  = 8'b0110_1000;
    free1 = 1'b1;
    match1 = 1'b1;
    cycle();
    check("f68.a_fidx", 32'(a_fidx), 32'd3);
    check("f68.a_fe",   32'(a_fe),   32'd0);
    check("f68.b_fidx", 32'(b_fidx), 32'd6);
    check("w1.c_fe",    32'(c_fe),   32'd0);
    check("w1.c_fidx",  32'(c_fidx), 32'd0);
    check("w1.c_mv",    32'(c_mv),   32'd1);
    check("w1.c_midx",  32'(c_midx), 32'd0);
    check("w1.c_me",    32'(c_me),   32'd0);

    free = 8'h80;
    cycle();
    check("f80.a_fidx", 32'(a_fidx), 32'd7);
    check("f80.b_fidx", 32'(b_fidx), 32'd7);

    free = 8'h01;
    cycle();
    check("f01.a_fidx", 32'(a_fidx), 32'd0);
    check("f01.b_fidx", 32'(b_fidx), 32'd0);
    check("f01.b_fe",   32'(b_fe),   32'd0);

    // Walking one-hot match; before each edge the previous result must remain.
    for (int i = 0; i < 8; i++) begin
      match = 8'h01 << i;
      #1;
      check("walk.pre_mv", 32'(a_mv), (i == 0) ? 32'd0 : 32'd1);
      check("walk.pre_idx", 32'(a_midx), (i == 0) ? 32'd0 : 32'(i - 1));
      cycle();
      check("walk.a_midx", 32'(a_midx), 32'(i));
      check("walk.a_mv",   32'(a_mv),   32'd1);
      check("walk.b_midx", 32'(b_midx), 32'(i));
    end

    match = 8'h00;
    cycle();
    check("m00.a_mv",   32'(a_mv),   32'd0);
    check("m00.a_midx", 32'(a_midx), 32'd0);

    match = 8'b0000_0110;
    cycle();
    check("multi.a_midx", 32'(a_midx), 32'd3);
    check("multi.a_mv",   32'(a_mv),   32'd1);
    check("multi.a_me",   32'(a_me),   32'(ERR_EXP));
    check("multi.b_me",   32'(b_me),   32'(ERR_EXP));

    free  = 8'h10;
    match = 8'h20;
    cycle();
    check_a("pre_hold", 3'd4, 1'b0, 3'd5, 1'b1, 1'b0);
    check("pre_hold.b_fidx", 32'(b_fidx), 32'd4);

    // Disabled edges discard whatever is on the inputs.
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      free  = 8'($urandom);
      match = 8'($urandom);
      cycle();
      check_a("hold", 3'd4, 1'b0, 3'd5, 1'b1, 1'b0);
      check("hold.b_fidx", 32'(b_fidx), 32'd4);
    end

    en    = 1'b1;
    free  = 8'h02;
    match = 8'h04;
    cycle();
    check_a("resume", 3'd1, 1'b0, 3'd2, 1'b1, 1'b0);
    check("resume.b_fidx", 32'(b_fidx), 32'd1);

    // Asynchronous reset between edges.
    free  = 8'hC0;
    match = 8'h08;
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    check("async_rst.b_fe", 32'(b_fe), 32'd1);
    check("async_rst.c_mv", 32'(c_mv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
